// File: rtl/interrupt_sequencer_if.sv
// Handshake and vector bus between the interrupt sequencer (master) and the
// instruction decoder (slave).
interface interrupt_sequencer_if;
  logic        i_flag;
  logic        sync;
  logic        rdy;
  logic        int_ack;
  logic        int_req;
  logic [1:0]  int_kind;
  logic [15:0] vector_addr;
  logic        vpb;
  logic        reset_stack;
  logic        set_i;

  modport master (
    input  i_flag, sync, rdy, int_ack,
    output int_req, int_kind, vector_addr, vpb, reset_stack, set_i
  );

  modport slave (
    output i_flag, sync, rdy, int_ack,
    input  int_req, int_kind, vector_addr, vpb, reset_stack, set_i
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Synchronises reset/NMI/IRQ, arbitrates them at instruction boundaries, runs the
// request/ack handshake with the decoder and drives the two vector-fetch cycles.
module interrupt_sequencer #(
  parameter int         SYNC_STAGES = 2,
  parameter int         RESET_HOLD  = 2,
  parameter logic [7:0] VECTOR_HI   = 8'hFF
) (
  input  logic                         fclk,
  input  logic                         resb,
  input  logic                         nmib,
  input  logic                         irqb,
  interrupt_sequencer_if.master        bus
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;
  localparam logic [1:0] S_VEC  = 2'd3;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_IRQ  = 2'b01;
  localparam logic [1:0] K_NMI  = 2'b10;
  localparam logic [1:0] K_RES  = 2'b11;

  function automatic logic [7:0] vec_lo(input logic [1:0] kind);
    case (kind)
      K_NMI:   return 8'hFA;
      K_IRQ:   return 8'hFE;
      default: return 8'hFC;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] nmib_sync_q;
  logic [SYNC_STAGES-1:0] irqb_sync_q;
  logic                   nmib_dly_q;
  logic                   nmi_latch_q, nmi_latch_d;

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        kind_q, kind_d;
  logic              fetch_q, fetch_d;
  logic              int_req_q, int_req_d;
  logic [15:0]       addr_q, addr_d;
  logic              vpb_q, vpb_d;
  logic              reset_stack_q, reset_stack_d;
  logic              set_i_q, set_i_d;

  logic nmib_s, irqb_s, nmi_edge, irq_active, accept, accept_nmi;

  assign nmib_s     = nmib_sync_q[SYNC_STAGES-1];
  assign irqb_s     = irqb_sync_q[SYNC_STAGES-1];
  assign nmi_edge   = nmib_dly_q & ~nmib_s;
  assign irq_active = ~irqb_s & ~bus.i_flag;
  assign accept     = (state_q == S_PEND) & bus.int_ack & bus.rdy;
  assign accept_nmi = accept & (kind_q == K_NMI);

  // An edge arriving on the accepting cycle re-arms the latch so it is not lost.
  assign nmi_latch_d = (nmi_latch_q & ~accept_nmi) | nmi_edge;

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      nmib_sync_q <= '1;
      irqb_sync_q <= '1;
      nmib_dly_q  <= 1'b1;
      nmi_latch_q <= 1'b0;
    end else begin
      nmib_sync_q <= {nmib_sync_q[SYNC_STAGES-2:0], nmib};
      irqb_sync_q <= {irqb_sync_q[SYNC_STAGES-2:0], irqb};
      nmib_dly_q  <= nmib_s;
      nmi_latch_q <= nmi_latch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    kind_d    = kind_q;
    fetch_d   = fetch_q;
    int_req_d = int_req_q;
    addr_d    = addr_q;
    vpb_d     = vpb_q;
    set_i_d   = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d   = S_PEND;
          kind_d    = K_RES;
          int_req_d = 1'b1;
          addr_d    = {VECTOR_HI, vec_lo(K_RES)};
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.sync && bus.rdy) begin
          if (nmi_latch_q) begin
            state_d   = S_PEND;
            kind_d    = K_NMI;
            int_req_d = 1'b1;
            addr_d    = {VECTOR_HI, vec_lo(K_NMI)};
          end else if (irq_active) begin
            state_d   = S_PEND;
            kind_d    = K_IRQ;
            int_req_d = 1'b1;
            addr_d    = {VECTOR_HI, vec_lo(K_IRQ)};
          end
        end
      end
      S_PEND: begin
        if (accept) begin
          state_d   = S_VEC;
          fetch_d   = 1'b0;
          int_req_d = 1'b0;
          vpb_d     = 1'b1;
        end
      end
      S_VEC: begin
        // Both fetches stall together with the decoder while rdy is low.
        if (bus.rdy) begin
          if (!fetch_q) begin
            fetch_d = 1'b1;
            addr_d  = {VECTOR_HI, vec_lo(kind_q) + 8'd1};
          end else begin
            state_d = S_IDLE;
            vpb_d   = 1'b0;
            addr_d  = {VECTOR_HI, vec_lo(K_RES)};
            set_i_d = (kind_q == K_IRQ) || (kind_q == K_NMI);
            kind_d  = K_NONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    reset_stack_d = (state_d == S_PEND) && (kind_d == K_RES);
  end

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state_q       <= S_HOLD;
      hold_q        <= '0;
      kind_q        <= K_NONE;
      fetch_q       <= 1'b0;
      int_req_q     <= 1'b0;
      addr_q        <= {VECTOR_HI, 8'hFC};
      vpb_q         <= 1'b0;
      reset_stack_q <= 1'b0;
      set_i_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      kind_q        <= kind_d;
      fetch_q       <= fetch_d;
      int_req_q     <= int_req_d;
      addr_q        <= addr_d;
      vpb_q         <= vpb_d;
      reset_stack_q <= reset_stack_d;
      set_i_q       <= set_i_d;
    end
  end

  assign bus.int_req     = int_req_q;
  assign bus.int_kind    = kind_q;
  assign bus.vector_addr = addr_q;
  assign bus.vpb         = vpb_q;
  assign bus.reset_stack = reset_stack_q;
  assign bus.set_i       = set_i_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: scenarios push the expected service
// order; an independent monitor checks each request, handshake and vector fetch.
module tb_interrupt_sequencer;
  localparam int SYNC_STAGES = 2;
  localparam int RESET_HOLD  = 2;

  logic fclk = 1'b0;
  logic resb = 1'b0;
  logic nmib = 1'b1;
  logic irqb = 1'b1;

  interrupt_sequencer_if bus();

  interrupt_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_HOLD (RESET_HOLD),
    .VECTOR_HI  (8'hFF)
  ) dut (
    .fclk(fclk),
    .resb(resb),
    .nmib(nmib),
    .irqb(irqb),
    .bus (bus)
  );

  always #5 fclk = ~fclk;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [1:0] exp_q[$];
  bit         rand_rdy = 1'b0;
  int         last_vlen = 0;
  int         n_done = 0;
  int         n_req = 0;

  // monitor state
  logic       e_rdy, e_ack, req_prev, in_vec, vec_end;
  logic [1:0] cur_kind;
  int         f, vlen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_lo(input logic [1:0] k);
    case (k)
      2'b11:   return 8'hFC;
      2'b10:   return 8'hFA;
      2'b01:   return 8'hFE;
      default: return 8'hFC;
    endcase
  endfunction

  function automatic logic [15:0] exp_base(input logic [1:0] k);
    return {8'hFF, exp_lo(k)};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    req_prev = 1'b0;
    in_vec   = 1'b0;
    cur_kind = 2'b00;
    f        = 0;
    vlen     = 0;
    forever begin
      @(posedge fclk);
      e_rdy = bus.rdy;
      e_ack = bus.int_ack;
      #1;
      if (!resb) begin
        req_prev = 1'b0;
        in_vec   = 1'b0;
      end else begin
        vec_end = 1'b0;
        if (in_vec) begin
          if (e_rdy) f++;
          if (f >= 2) begin
            vec_end   = 1'b1;
            in_vec    = 1'b0;
            last_vlen = vlen;
            n_done++;
            chk("end_vpb", 32'(bus.vpb), 32'd0);
            chk("end_addr", 32'(bus.vector_addr), 32'hFFFC);
            chk("end_kind", 32'(bus.int_kind), 32'd0);
          end else begin
            vlen++;
            chk("vec_vpb", 32'(bus.vpb), 32'd1);
            chk("vec_addr", 32'(bus.vector_addr), 32'(exp_base(cur_kind) + 16'(f)));
          end
        end else if (req_prev && !bus.int_req) begin
          chk("accept_handshake", 32'({e_ack, e_rdy}), 32'd3);
          chk("fetch0_vpb", 32'(bus.vpb), 32'd1);
          chk("fetch0_addr", 32'(bus.vector_addr), 32'(exp_base(cur_kind)));
          in_vec = 1'b1;
          f      = 0;
          vlen   = 1;
        end else if (!req_prev && bus.int_req) begin
          n_req++;
          if (exp_q.size() == 0) begin
            chk("unexpected_req", 32'(bus.int_req), 32'd0);
            cur_kind = bus.int_kind;
          end else begin
            cur_kind = exp_q.pop_front();
            chk("req_kind", 32'(bus.int_kind), 32'(cur_kind));
          end
          chk("req_addr", 32'(bus.vector_addr), 32'(exp_base(cur_kind)));
          chk("req_reset_stack", 32'(bus.reset_stack), 32'(cur_kind == 2'b11));
        end else if (bus.int_req) begin
          chk("pend_kind", 32'(bus.int_kind), 32'(cur_kind));
          chk("pend_addr", 32'(bus.vector_addr), 32'(exp_base(cur_kind)));
          chk("pend_reset_stack", 32'(bus.reset_stack), 32'(cur_kind == 2'b11));
        end else begin
          chk("idle_vpb", 32'(bus.vpb), 32'd0);
        end
        chk("set_i", 32'(bus.set_i), vec_end ? 32'(cur_kind != 2'b11) : 32'd0);
        req_prev = bus.int_req;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge fclk);
    if (rand_rdy) bus.rdy = ($urandom_range(0, 3) != 0);
    bus.int_ack = bus.int_req & (bus.int_ack | ($urandom_range(0, 2) == 0));
  endtask

  task automatic wait_req(input int sync_every);
    int k = 0;
    while (!bus.int_req && k < 300) begin
      bus.sync = ($urandom_range(0, sync_every - 1) == 0);
      tick();
      k++;
    end
    bus.sync = 1'b0;
    chk("req_timeout", 32'(bus.int_req), 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    bus.sync = 1'b0;
    while ((bus.int_req || bus.vpb) && k < 300) begin
      tick();
      k++;
    end
    tick();
    chk("idle_timeout", 32'(bus.int_req | bus.vpb), 32'd0);
  endtask

  task automatic run_scn(input bit nmi, input bit irq, input bit ifl);
    int n_exp = 0;
    bus.sync   = 1'b0;
    bus.i_flag = ifl;
    if (nmi) begin exp_q.push_back(2'b10); n_exp++; end
    if (irq && !ifl) begin exp_q.push_back(2'b01); n_exp++; end
    if (irq) irqb = 1'b0;
    if (nmi) nmib = 1'b0;
    repeat (SYNC_STAGES + 3) tick();
    for (int s = 0; s < n_exp; s++) begin
      wait_req(3);
      if (s == n_exp - 1) irqb = 1'b1;
      wait_idle();
    end
    if (n_exp == 0) begin
      repeat (20) begin
        bus.sync = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus.sync = 1'b0;
    nmib = 1'b1;
    irqb = 1'b1;
    repeat (SYNC_STAGES + 2) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, r0;
    bus.i_flag  = 1'b1;
    bus.sync    = 1'b0;
    bus.rdy     = 1'b1;
    bus.int_ack = 1'b0;

    // reset values
    repeat (2) @(negedge fclk);
    chk("rst_int_req", 32'(bus.int_req), 32'd0);
    chk("rst_kind", 32'(bus.int_kind), 32'd0);
    chk("rst_addr", 32'(bus.vector_addr), 32'hFFFC);
    chk("rst_vpb", 32'(bus.vpb), 32'd0);
    chk("rst_reset_stack", 32'(bus.reset_stack), 32'd0);
    chk("rst_set_i", 32'(bus.set_i), 32'd0);

    // test 1: reset service after RESET_HOLD edges
    exp_q.push_back(2'b11);
    resb = 1'b1;
    tick();
    chk("t1_req_edge1", 32'(bus.int_req), 32'd0);
    tick();
    chk("t1_req_edge2", 32'(bus.int_req), 32'd1);
    chk("t1_kind", 32'(bus.int_kind), 32'd3);
    chk("t1_reset_stack", 32'(bus.reset_stack), 32'd1);
    wait_idle();
    bus.i_flag = 1'b0;

    // test 2: held-low NMI yields exactly one service
    rand_rdy = 1'b1;
    d0 = n_done;
    exp_q.push_back(2'b10);
    nmib = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.sync = (i % 4 == 0);
      tick();
    end
    nmib = 1'b1;
    wait_idle();
    repeat (6) tick();
    chk("t2_nmi_once", 32'(n_done - d0), 32'd1);

    // test 3: masked IRQ, then unmasked
    r0 = n_req;
    irqb = 1'b0;
    bus.i_flag = 1'b1;
    repeat (20) begin
      bus.sync = 1'($urandom_range(0, 1));
      tick();
    end
    bus.sync = 1'b0;
    chk("t3_masked_irq", 32'(n_req - r0), 32'd0);
    exp_q.push_back(2'b01);
    bus.i_flag = 1'b0;
    wait_req(4);
    chk("t3_irq_kind", 32'(bus.int_kind), 32'd1);
    irqb = 1'b1;
    wait_idle();
    repeat (4) tick();

    // test 4: NMI and IRQ at the same boundary
    run_scn(1'b1, 1'b1, 1'b0);

    // test 5: rdy low for three cycles during fetch 0
    rand_rdy = 1'b0;
    bus.rdy  = 1'b1;
    exp_q.push_back(2'b10);
    nmib = 1'b0;
    repeat (SYNC_STAGES + 3) tick();
    wait_req(2);
    nmib = 1'b1;
    begin
      int k = 0;
      while (!bus.vpb && k < 100) begin tick(); k++; end
    end
    chk("t5_vpb_seen", 32'(bus.vpb), 32'd1);
    bus.rdy = 1'b0;
    repeat (3) tick();
    chk("t5_stall_addr", 32'(bus.vector_addr), 32'hFFFA);
    bus.rdy = 1'b1;
    wait_idle();
    chk("t5_vpb_len", 32'(last_vlen), 32'd5);

    // test 6: reset during fetch 1 of an NMI
    exp_q.push_back(2'b10);
    nmib = 1'b0;
    repeat (SYNC_STAGES + 3) tick();
    wait_req(2);
    nmib = 1'b1;
    begin
      int k = 0;
      while (!(bus.vpb && bus.vector_addr == 16'hFFFB) && k < 100) begin tick(); k++; end
    end
    chk("t6_fetch1_seen", 32'(bus.vector_addr), 32'hFFFB);
    #2 resb = 1'b0;
    #1;
    chk("t6_async_vpb", 32'(bus.vpb), 32'd0);
    chk("t6_async_req", 32'(bus.int_req), 32'd0);
    chk("t6_async_addr", 32'(bus.vector_addr), 32'hFFFC);
    chk("t6_async_kind", 32'(bus.int_kind), 32'd0);
    exp_q.delete();
    exp_q.push_back(2'b11);
    tick();
    resb = 1'b1;
    tick();
    chk("t6_req_edge1", 32'(bus.int_req), 32'd0);
    tick();
    chk("t6_req_edge2", 32'(bus.int_req), 32'd1);
    chk("t6_kind", 32'(bus.int_kind), 32'd3);
    wait_idle();
    repeat (6) tick();

    // randomized scenarios
    rand_rdy = 1'b1;
    for (int it = 0; it < 40; it++) begin
      run_scn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (10) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
